ramp_line_scanner: RTL and testbench
====================================

// Module: ramp_line_scanner
// PURPOSE
//  Read-side initiator for the registered ramp line array (entry i = base + i).
//  Drives sel across all DEPTH entries, consumes the registered line data,
//  checks each entry against base + index (mod 2^WIDTH), and reports pass/fail
//  with the first failing index and data. Sits beside the array as a self-check engine.
// PARAMETERS
//  WIDTH  8  data width of line / base (ramp arithmetic wraps mod 2^WIDTH)
//  DEPTH  3  number of valid array entries scanned (indices 0..DEPTH-1)
//  SEL_W  2  width of sel; DEPTH <= 2**SEL_W (elaboration error otherwise)
// PORTS
//  clk       in   1      single clock, all state on posedge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request scan; sampled only in IDLE
//  base_in   in   WIDTH  expected ramp base; captured on accepted start
//  cont      in   1      continuous-mode request (used only with RAMP_SCAN_CONT_EN)
//  sel       out  SEL_W  registered read index to array
//  line      in   WIDTH  array read data; valid the cycle after sel presents index
//  busy      out  1      high from cycle after accepted start until done cycle (excl.)
//  done      out  1      one-cycle pulse when scan result is final
//  pass      out  1      result of last scan; held until next accepted start
//  err_idx   out  SEL_W  index of first mismatch (0 if pass)
//  err_data  out  WIDTH  line value at first mismatch (0 if pass)
// BEHAVIOUR
//  - Reset: state IDLE; sel=0, busy=0, done=0, pass=0, err_idx=0, err_data=0.
//    Reset mid-scan aborts: no done pulse, results cleared, next start scans from 0.
//  - FSM: IDLE -> SCAN on start; SCAN -> DRAIN after issuing index DEPTH-1;
//    DRAIN -> DONE when last compare retires; DONE -> IDLE (or SCAN, see CONFIG).
//  - Timing (start high in cycle 0): sel=i in cycle 1+i, i=0..DEPTH-1;
//    line for index i sampled cycle 2+i; compare result registered end of that
//    cycle; done=1 in cycle DEPTH+2; busy=1 cycles 1..DEPTH+1.
//  - Compare pipeline carries (vld, idx); expected = base_q + idx, truncated to WIDTH.
//  - First mismatch latches err_idx/err_data and clears pass; later mismatches in
//    same scan do not overwrite. pass=1 only if all DEPTH compares match.
//  - On accepted start: pass, err_idx, err_data cleared to 0 immediately (cycle 1).
//  - start while busy/DONE ignored (no queueing). sel never exceeds DEPTH-1:
//    out-of-bounds entries are never read. sel returns to 0 in DRAIN/IDLE.
//  - base wrap: base=8'hFF, DEPTH=3 expects FF,00,01.
// CONFIGURATION
//  RAMP_SCAN_CONT_EN defined: if cont=1 in the DONE cycle, FSM goes DONE->SCAN,
//    reusing base_q; sel=0 the next cycle; done still pulses once per scan; pass/err
//    cleared at restart. cont=0 -> IDLE.
//  Not defined: cont ignored; DONE always -> IDLE.
// STRUCTURE
//  Package ramp_scan_pkg: state enum (IDLE,SCAN,DRAIN,DONE), default WIDTH/DEPTH/SEL_W.
//  Sub-module ramp_cmp_stage: one registered compare stage (vld, idx, line, base ->
//    hit/miss, idx, data); FSM, sel counter and result latch stay in top.
// TESTING
//  1 base=8'h10, array 10,11,12 -> sel 0,1,2 in cycles 1-3, done cycle 5, pass=1.
//  2 base=8'hFF, array FF,00,01 -> pass=1 (wrap verified).
//  3 base=8'h20, array 20,99,98 -> pass=0, err_idx=1, err_data=8'h99 (first kept).
//  4 start pulsed again in cycles 2-4 -> ignored; exactly one done, same result.
//  5 rst in cycle 3 of scan -> no done, outputs 0; new start scans normally.
//  6 RAMP_SCAN_CONT_EN, cont=1 -> back-to-back scans, done every DEPTH+2 cycles.

Source files
------------

// File: rtl/ramp_line_scanner_pkg.sv
// Shared types and default sizing for the ramp line scanner and its compare stage.
// Contents: scan FSM state enum, default WIDTH / DEPTH / SEL_W.
// Imported by the interface, the compare stage and the top.
package ramp_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;
  localparam int DEF_SEL_W = 2;

endpackage

// File: rtl/ramp_line_scanner_if.sv
// Control, array-read and result signals between the ramp line scanner and its environment.
// master : scanner side (drives sel and results, receives start/base_in/cont/line).
// slave  : environment side (drives start/base_in/cont and the array read data line).
interface ramp_line_scanner_if
  import ramp_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
);

  logic             start;
  logic [WIDTH-1:0] base_in;
  logic             cont;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] line;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SEL_W-1:0] err_idx;
  logic [WIDTH-1:0] err_data;

  modport master (
    input  start, base_in, cont, line,
    output sel, busy, done, pass, err_idx, err_data
  );

  modport slave (
    output start, base_in, cont, line,
    input  sel, busy, done, pass, err_idx, err_data
  );

endinterface

// File: rtl/ramp_line_scanner_cmp.sv
// One registered compare stage: checks a line against base + idx (mod 2^WIDTH).
// Ports: clk, rst; vld/idx/line/base in; res_vld/miss/res_idx/res_data out, one cycle later.
// miss is only ever set alongside res_vld; res_idx/res_data hold the last valid entry.
module ramp_cmp_stage
  import ramp_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [SEL_W-1:0] idx,
  input  logic [WIDTH-1:0] line,
  input  logic [WIDTH-1:0] base,
  output logic             res_vld,
  output logic             miss,
  output logic [SEL_W-1:0] res_idx,
  output logic [WIDTH-1:0] res_data
);

  // Ramp arithmetic wraps naturally by truncating to WIDTH.
  logic [WIDTH-1:0] expected;
  assign expected = base + WIDTH'(idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld  <= 1'b0;
      miss     <= 1'b0;
      res_idx  <= '0;
      res_data <= '0;
    end else begin
      res_vld <= vld;
      miss    <= vld && (line != expected);
      if (vld) begin
        res_idx  <= idx;
        res_data <= line;
      end
    end
  end

endmodule

// File: rtl/ramp_line_scanner.sv
// Read-side self-check engine for a registered ramp line array (entry i = base + i).
// Ports: clk, rst (sync, active-high), bus (ramp_line_scanner_if.master): start/base_in/cont
//   in, sel out to the array, line back from it, busy/done/pass/err_idx/err_data results.
// Option macro RAMP_SCAN_CONT_EN: cont=1 in the done cycle restarts a scan with the same base.
module ramp_line_scanner
  import ramp_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input logic                clk,
  input logic                rst,
  ramp_line_scanner_if.master bus
);

  generate
    if (DEPTH < 1 || DEPTH > (1 << SEL_W)) begin : g_bad_depth
      $error("ramp_line_scanner: DEPTH must be in 1..2**SEL_W");
    end
  endgenerate

  localparam logic [SEL_W-1:0] LAST = SEL_W'(DEPTH - 1);

  scan_state_t      state;
  logic [SEL_W-1:0] sel_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] base_q;

  // Issue pipe: tags the index whose data arrives on line this cycle.
  logic             iss_vld;
  logic [SEL_W-1:0] iss_idx;

  // Compare stage outputs.
  logic             res_vld;
  logic             miss;
  logic [SEL_W-1:0] res_idx;
  logic [WIDTH-1:0] res_data;

  // Result latch.
  logic             err_seen_q;
  logic [SEL_W-1:0] err_idx_q;
  logic [WIDTH-1:0] err_data_q;
  logic             pass_q;

  logic restart;
  logic clear;
  logic new_miss;
  logic err_seen;

`ifdef RAMP_SCAN_CONT_EN
  assign restart = bus.cont;
`else
  logic unused_cont;
  assign unused_cont = bus.cont;
  assign restart     = 1'b0;
`endif

  // Results are wiped on an accepted start or on a continuous-mode restart.
  assign clear = ((state == IDLE) && bus.start) || ((state == DONE) && restart);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      base_q  <= '0;
      iss_vld <= 1'b0;
      iss_idx <= '0;
    end else begin
      iss_vld <= (state == SCAN);
      iss_idx <= sel_q;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SCAN;
            sel_q  <= '0;
            busy_q <= 1'b1;
            base_q <= bus.base_in;
          end
        end
        SCAN: begin
          // sel stops at LAST, so entries beyond DEPTH-1 are never addressed.
          if (sel_q == LAST) begin
            state <= DRAIN;
            sel_q <= '0;
          end else begin
            sel_q <= sel_q + SEL_W'(1);
          end
        end
        DRAIN: begin
          // Last index's data is on line now; its compare registers this edge.
          if (iss_vld && (iss_idx == LAST)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          if (restart) begin
            state  <= SCAN;
            sel_q  <= '0;
            busy_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ramp_cmp_stage #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .vld      (iss_vld),
    .idx      (iss_idx),
    .line     (bus.line),
    .base     (base_q),
    .res_vld  (res_vld),
    .miss     (miss),
    .res_idx  (res_idx),
    .res_data (res_data)
  );

  // The final compare lands in the done cycle itself, so the visible results
  // merge the latch with the stage output; the latch absorbs it on that edge.
  assign new_miss = res_vld && miss && !err_seen_q;
  assign err_seen = err_seen_q || (res_vld && miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_seen_q <= 1'b0;
      err_idx_q  <= '0;
      err_data_q <= '0;
      pass_q     <= 1'b0;
    end else if (clear) begin
      err_seen_q <= 1'b0;
      err_idx_q  <= '0;
      err_data_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      if (new_miss) begin
        err_seen_q <= 1'b1;
        err_idx_q  <= res_idx;
        err_data_q <= res_data;
      end
      if (done_q) begin
        pass_q <= !err_seen;
      end
    end
  end

  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = done_q ? !err_seen : pass_q;
  assign bus.err_idx  = new_miss ? res_idx : err_idx_q;
  assign bus.err_data = new_miss ? res_data : err_data_q;

endmodule

// File: tb/tb_ramp_line_scanner.sv
// Directed bench for ramp_line_scanner with a registered 4-entry array model.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Cycle c of a scan is the cycle after the c-th rising edge following start.
module tb_ramp_line_scanner;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ramp_line_scanner_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  ramp_line_scanner #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered array: line follows sel by one cycle.
  logic [WIDTH-1:0] arr [0:3];
  always @(posedge clk) bus.line <= arr[bus.sel];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full scan from IDLE; optionally re-pulses start in cycles 2..4.
  task automatic scan(input logic [7:0] b, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input logic ep, input logic [1:0] ei,
                      input logic [7:0] ed, input bit pulses);
    arr[0] = a0; arr[1] = a1; arr[2] = a2; arr[3] = 8'hEE;
    bus.base_in = b;
    bus.start   = 1'b1;
    for (int c = 1; c <= DEPTH + 2; c++) begin
      tick();
      bus.start = pulses && (c >= 2) && (c <= 4);
      if (c == 1) begin
        chk("clr_pass", bus.pass, 0);
        chk("clr_err_idx", bus.err_idx, 0);
        chk("clr_err_data", bus.err_data, 0);
      end
      if (c <= DEPTH) begin
        chk("sel", bus.sel, c - 1);
        chk("busy_scan", bus.busy, 1);
        chk("done_scan", bus.done, 0);
      end else if (c == DEPTH + 1) begin
        chk("sel_drain", bus.sel, 0);
        chk("busy_drain", bus.busy, 1);
        chk("done_drain", bus.done, 0);
      end else begin
        chk("done_pulse", bus.done, 1);
        chk("busy_done", bus.busy, 0);
        chk("pass", bus.pass, ep);
        chk("err_idx", bus.err_idx, ei);
        chk("err_data", bus.err_data, ed);
      end
    end
    tick();
    chk("done_end", bus.done, 0);
    chk("busy_end", bus.busy, 0);
    chk("pass_held", bus.pass, ep);
    chk("err_idx_held", bus.err_idx, ei);
    chk("err_data_held", bus.err_data, ed);
    if (pulses) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("no_second_done", bus.done, 0);
        chk("no_second_busy", bus.busy, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    bus.start   = 1'b0;
    bus.base_in = '0;
    bus.cont    = 1'b0;
    for (int i = 0; i < 4; i++) arr[i] = '0;
    tick();
    tick();
    chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_err_idx", bus.err_idx, 0);
    chk("rst_err_data", bus.err_data, 0);
    rst = 1'b0;
    tick();

    // 1: plain ramp
    scan(8'h10, 8'h10, 8'h11, 8'h12, 1'b1, 2'd0, 8'h00, 1'b0);
    // 2: base wraps FF -> 00 -> 01
    scan(8'hFF, 8'hFF, 8'h00, 8'h01, 1'b1, 2'd0, 8'h00, 1'b0);
    // 3: two mismatches, first one kept
    scan(8'h20, 8'h20, 8'h99, 8'h98, 1'b0, 2'd1, 8'h99, 1'b0);
    // 4: start re-pulsed while busy is ignored
    scan(8'h20, 8'h20, 8'h99, 8'h98, 1'b0, 2'd1, 8'h99, 1'b1);

    // 5: reset in cycle 3 aborts after index 0 has already mismatched
    arr[0] = 8'h77; arr[1] = 8'h31; arr[2] = 8'h32;
    bus.base_in = 8'h30;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("abort_err_data_pre", bus.err_data, 8'h77);
    chk("abort_busy_pre", bus.busy, 1);
    chk("abort_sel_pre", bus.sel, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sel", bus.sel, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_pass", bus.pass, 0);
    chk("abort_err_data", bus.err_data, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", bus.done, 0);
      chk("abort_idle", bus.busy, 0);
    end
    scan(8'h40, 8'h40, 8'h41, 8'h42, 1'b1, 2'd0, 8'h00, 1'b0);

`ifdef RAMP_SCAN_CONT_EN
    // 6: continuous mode, three back-to-back scans then stop
    arr[0] = 8'h10; arr[1] = 8'h11; arr[2] = 8'h12;
    bus.base_in = 8'h10;
    bus.cont    = 1'b1;
    bus.start   = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      bus.start = 1'b0;
      chk("cont_done", bus.done, (c % 5) == 0);
      if ((c % 5) == 1) begin
        chk("cont_sel0", bus.sel, 0);
        chk("cont_busy", bus.busy, 1);
        chk("cont_clr_pass", bus.pass, 0);
      end
      if ((c % 5) == 0) chk("cont_pass", bus.pass, 1);
      if (c == 15) bus.cont = 1'b0;
    end
    tick();
    chk("cont_stop_busy", bus.busy, 0);
    chk("cont_stop_done", bus.done, 0);
    tick();
    chk("cont_stop_idle", bus.busy, 0);
`else
    // cont is ignored: scan finishes and the engine stays idle
    bus.cont = 1'b1;
    scan(8'h10, 8'h10, 8'h11, 8'h12, 1'b1, 2'd0, 8'h00, 1'b0);
    tick();
    chk("nocont_idle", bus.busy, 0);
    chk("nocont_done", bus.done, 0);
    bus.cont = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
